// File: rtl/bpsk_frame_controller.sv
// BPSK receive framer: starts the demodulator, hunts for a sync word, reads a length byte and
// hands payload bytes out through a one-entry valid/ready buffer. Optional: BPSK_POLARITY_RESOLVE_EN.
module bpsk_frame_controller #(
  parameter int unsigned              SYNC_WIDTH  = 16,
  parameter logic [SYNC_WIDTH-1:0]    SYNC_WORD   = 16'h2DD4,
  parameter int unsigned              MAX_PAYLOAD = 32,
  parameter int unsigned              GAP_LIMIT   = 256
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       bit_valid_i,
  input  logic       bit_value_i,
  output logic       demod_start_o,
  output logic [7:0] byte_data_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       frame_error_o,
  output logic       busy_o
);

  localparam int unsigned GapW = $clog2(GAP_LIMIT) + 1;
  localparam logic [GapW-1:0] GapMax = GapW'(GAP_LIMIT);
  localparam logic [GapW-1:0] GapOne = GapW'(1);
  localparam logic [7:0] MaxLen = 8'(MAX_PAYLOAD);

  typedef enum logic [1:0] {StIdle, StHunt, StLength, StPayload} state_e;

  state_e                state_q, state_d;
  // Only SYNC_WIDTH-1 history bits are kept; the incoming bit completes the compare window.
  logic [SYNC_WIDTH-2:0] shift_q, shift_d;
  logic [6:0]            byte_sr_q, byte_sr_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [7:0]            remaining_q, remaining_d;
  logic [7:0]            byte_data_q, byte_data_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  demod_start_q, demod_start_d;
  logic                  frame_start_q, frame_start_d;
  logic                  frame_end_q, frame_end_d;
  logic                  frame_error_q, frame_error_d;
  logic                  busy_q, busy_d;

  logic                  bit_in;
  logic [SYNC_WIDTH-1:0] window;
  logic [7:0]            byte_next;
  logic                  buf_free;

`ifdef BPSK_POLARITY_RESOLVE_EN
  logic inv_q, inv_d;
  assign bit_in = bit_value_i ^ inv_q;
`else
  assign bit_in = bit_value_i;
`endif

  assign window    = {shift_q, bit_value_i};
  assign byte_next = {byte_sr_q, bit_in};
  // Accepting in the same cycle frees the slot for a byte completing now.
  assign buf_free  = !byte_valid_q || byte_ready_i;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    byte_sr_d     = byte_sr_q;
    bit_cnt_d     = bit_cnt_q;
    gap_d         = gap_q;
    remaining_d   = remaining_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = byte_valid_q && !byte_ready_i;
    demod_start_d = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_error_d = 1'b0;
`ifdef BPSK_POLARITY_RESOLVE_EN
    inv_d         = inv_q;
`endif

    if (state_q == StIdle) begin
      gap_d = '0;
      if (enable_i) begin
        state_d       = StHunt;
        demod_start_d = 1'b1;
        shift_d       = '0;
      end
    end else if (!enable_i) begin
      state_d   = StIdle;
      shift_d   = '0;
      gap_d     = '0;
      bit_cnt_d = '0;
`ifdef BPSK_POLARITY_RESOLVE_EN
      inv_d     = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StHunt: begin
          gap_d = '0;
          if (bit_valid_i) begin
            shift_d = window[SYNC_WIDTH-2:0];
            if (window == SYNC_WORD) begin
              state_d       = StLength;
              frame_start_d = 1'b1;
              bit_cnt_d     = '0;
            end
`ifdef BPSK_POLARITY_RESOLVE_EN
            else if (window == ~SYNC_WORD) begin
              state_d       = StLength;
              frame_start_d = 1'b1;
              bit_cnt_d     = '0;
              inv_d         = 1'b1;
            end
`endif
          end
        end

        StLength, StPayload: begin
          if (bit_valid_i) begin
            gap_d     = '0;
            byte_sr_d = byte_next[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == StLength) begin
                if (byte_next == 8'd0 || byte_next > MaxLen) begin
                  state_d       = StHunt;
                  frame_error_d = 1'b1;
                end else begin
                  state_d     = StPayload;
                  remaining_d = byte_next;
                end
              end else if (buf_free) begin
                byte_data_d  = byte_next;
                byte_valid_d = 1'b1;
                remaining_d  = remaining_q - 8'd1;
                if (remaining_q == 8'd1) begin
                  state_d     = StHunt;
                  frame_end_d = 1'b1;
                end
              end else begin
                // Overflow: drop the new byte, keep the pending one.
                state_d       = StHunt;
                frame_error_d = 1'b1;
              end
            end
          end else begin
            gap_d = gap_q + GapOne;
            if (gap_d == GapMax) begin
              state_d       = StHunt;
              frame_error_d = 1'b1;
            end
          end
          if (state_d == StHunt) begin
            shift_d   = '0;
            gap_d     = '0;
            bit_cnt_d = '0;
`ifdef BPSK_POLARITY_RESOLVE_EN
            inv_d     = 1'b0;
`endif
          end
        end

        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d == StLength) || (state_d == StPayload);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      shift_q       <= '0;
      byte_sr_q     <= '0;
      bit_cnt_q     <= '0;
      gap_q         <= '0;
      remaining_q   <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      demod_start_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef BPSK_POLARITY_RESOLVE_EN
      inv_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      byte_sr_q     <= byte_sr_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_q         <= gap_d;
      remaining_q   <= remaining_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      demod_start_q <= demod_start_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
`ifdef BPSK_POLARITY_RESOLVE_EN
      inv_q         <= inv_d;
`endif
    end
  end

  assign demod_start_o = demod_start_q;
  assign byte_data_o   = byte_data_q;
  assign byte_valid_o  = byte_valid_q;
  assign frame_start_o = frame_start_q;
  assign frame_end_o   = frame_end_q;
  assign frame_error_o = frame_error_q;
  assign busy_o        = busy_q;

endmodule
